// File: rtl/pld_load_sequencer.sv
// Feeder for the parallel-load shift register: buffers upstream words in a
// small FIFO and releases one word with a single-cycle load strobe every
// PERIOD clocks. A window that ends with nothing queued raises underrun.
module pld_load_sequencer #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PERIOD = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    input  logic [WIDTH-1:0]         in_data_i,
    output logic                     in_ready_o,
    output logic                     load_o,
    output logic [WIDTH-1:0]         din_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     underrun_o
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned LevelW = PtrW + 1;
    localparam int unsigned CntW   = $clog2(PERIOD);

    localparam logic [LevelW-1:0] LevelFull = LevelW'(DEPTH);
    localparam logic [CntW-1:0]   CntLast   = CntW'(PERIOD - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]    din_q, din_d;
    logic                underrun_q, underrun_d;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PtrW-1:0]     wptr_q, wptr_d;
    logic [PtrW-1:0]     rptr_q, rptr_d;
    logic [LevelW-1:0]   level_q, level_d;

    logic                push;
    logic                pop;
    logic                fifo_empty;

    // Handshake: ready depends only on registered level and reset, never on valid.
    always_comb begin
        fifo_empty = (level_q == '0);
        in_ready_o = (level_q != LevelFull) & rst_ni;
        push       = in_valid_i & in_ready_o;
    end

    // Sequencer next state; a pop always coincides with entry into StLoad.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        din_d      = din_q;
        underrun_d = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StLoad;
                    pop     = 1'b1;
                    cnt_d   = '0;
                    din_d   = mem_q[rptr_q];
                end
            end
            StLoad: begin
                state_d = StShift;
                cnt_d   = CntW'(1);
            end
            StShift: begin
                if (cnt_q == CntLast) begin
                    if (!fifo_empty) begin
                        state_d = StLoad;
                        pop     = 1'b1;
                        cnt_d   = '0;
                        din_d   = mem_q[rptr_q];
                    end else begin
                        // Window closed with no word ready: report the gap.
                        state_d    = StIdle;
                        underrun_d = 1'b1;
                        cnt_d      = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // FIFO pointer and level bookkeeping; push and pop together leave level unchanged.
    always_comb begin
        wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PtrW'(1) : rptr_q;
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LevelW'(1);
            2'b01:   level_d = level_q - LevelW'(1);
            default: level_d = level_q;
        endcase
    end

    // Control and FIFO state registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            din_q      <= '0;
            underrun_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            din_q      <= din_d;
            underrun_q <= underrun_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
        end
    end

    // FIFO storage; cleared on reset so flushed contents never reappear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wptr_q] <= in_data_i;
        end
    end

    // Outputs are taken straight from registered state.
    always_comb begin
        load_o       = (state_q == StLoad);
        din_o        = din_q;
        fifo_level_o = level_q;
        underrun_o   = underrun_q;
    end

endmodule
